// File: rtl/ndn_rx_packet_assembler.sv
// -----------------------------------------------------------------------------
// ndn_rx_packet_assembler
//
// Rebuilds NDN packets from the SPI receive byte stream and offers each
// complete packet to the FIB lookup stage.
//
// Stream format: one metadata byte (bit 6 = interest, bits 5:0 = prefix
// length, bit 7 ignored), PREFIX_BYTES prefix bytes, then DATA_BYTES payload
// bytes for data packets only. A single packet is held at a time. Bytes that
// arrive while a finished packet is waiting are dropped and counted.
//
// Handshake: pkt_valid is high while a complete packet sits on the pkt_*
// outputs, which stay stable until the cycle after an edge where
// pkt_valid && pkt_ready (the transfer edge). pkt_ready is ignored while
// pkt_valid is low.
//
// Optional feature, macro NDN_RX_ASM_TIMEOUT_EN: when defined, a partial packet
// is aborted after TIMEOUT_CYCLES consecutive cycles without rx_valid in the
// PREFIX or DATA state. When undefined, partial packets wait indefinitely.
//
// Ports:
//   clk             in   clock, rising edge
//   rst             in   asynchronous active-high reset
//   rx_valid        in   rx_byte carries a stream byte this cycle
//   rx_byte[7:0]    in   stream byte
//   pkt_valid       out  complete packet present
//   pkt_ready       in   downstream accepts packet when pkt_valid is high
//   pkt_is_interest out  metadata bit 6
//   pkt_prefix_len  out  metadata bits 5:0
//   pkt_prefix      out  prefix, first byte in the MSBs
//   pkt_data        out  payload, first byte in the MSBs (zero for interest)
//   drop_count      out  saturating count of dropped bytes
//   err_pulse       out  one-cycle pulse after a drop or timeout abort
//   dbg_state[1:0]  out  current FSM state (IDLE=0, PREFIX=1, DATA=2, HOLD=3)
// -----------------------------------------------------------------------------
module ndn_rx_packet_assembler #(
  parameter int PREFIX_BYTES   = 8,
  parameter int DATA_BYTES     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx_valid,
  input  logic [7:0]                rx_byte,
  output logic                      pkt_valid,
  input  logic                      pkt_ready,
  output logic                      pkt_is_interest,
  output logic [5:0]                pkt_prefix_len,
  output logic [PREFIX_BYTES*8-1:0] pkt_prefix,
  output logic [DATA_BYTES*8-1:0]   pkt_data,
  output logic [7:0]                drop_count,
  output logic                      err_pulse,
  output logic [1:0]                dbg_state
);

  localparam int PW        = PREFIX_BYTES * 8;
  localparam int DW        = DATA_BYTES * 8;
  localparam int MAX_BYTES = (PREFIX_BYTES > DATA_BYTES) ? PREFIX_BYTES : DATA_BYTES;
  localparam int CNT_W     = $clog2(MAX_BYTES + 1);

  localparam logic [CNT_W-1:0] PREFIX_LAST = CNT_W'(PREFIX_BYTES - 1);
  localparam logic [CNT_W-1:0] DATA_LAST   = CNT_W'(DATA_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PREFIX = 2'd1,
    S_DATA   = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Datapath controls decoded by the next-state logic.
  logic start_pkt;     // current byte is a metadata byte
  logic shift_prefix;  // current byte is a prefix byte
  logic shift_data;    // current byte is a payload byte
  logic drop_byte;     // byte arrived while a finished packet waits
  logic abort;         // inter-byte timeout expired this cycle

  // ---------------------------------------------------------------------------
  // Inter-byte timeout
  // ---------------------------------------------------------------------------
`ifdef NDN_RX_ASM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] idle_q;
  logic          in_body;

  assign in_body = (state_q == S_PREFIX) || (state_q == S_DATA);

  // The abort fires on the edge that ends the TIMEOUT_CYCLES-th idle cycle.
  assign abort = in_body && !rx_valid && (idle_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_q <= '0;
    end else if (in_body && !rx_valid && !abort) begin
      idle_q <= idle_q + 1'b1;
    end else begin
      idle_q <= '0;
    end
  end
`else
  // Timeout not compiled in: the comparison is constant false.
  assign abort = (TIMEOUT_CYCLES < 0);
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    start_pkt    = 1'b0;
    shift_prefix = 1'b0;
    shift_data   = 1'b0;
    drop_byte    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          start_pkt = 1'b1;
          cnt_d     = PREFIX_LAST;
          state_d   = S_PREFIX;
        end
      end

      S_PREFIX: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (rx_valid) begin
          shift_prefix = 1'b1;
          if (cnt_q == '0) begin
            if (pkt_is_interest) begin
              state_d = S_HOLD;
            end else begin
              cnt_d   = DATA_LAST;
              state_d = S_DATA;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end

      S_DATA: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (rx_valid) begin
          shift_data = 1'b1;
          if (cnt_q == '0) begin
            state_d = S_HOLD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end

      S_HOLD: begin
        if (pkt_ready) begin
          // A byte on the transfer edge is the next packet's metadata.
          if (rx_valid) begin
            start_pkt = 1'b1;
            cnt_d     = PREFIX_LAST;
            state_d   = S_PREFIX;
          end else begin
            state_d = S_IDLE;
          end
        end else if (rx_valid) begin
          drop_byte = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_is_interest <= 1'b0;
      pkt_prefix_len  <= '0;
      pkt_prefix      <= '0;
      pkt_data        <= '0;
    end else if (start_pkt) begin
      pkt_is_interest <= rx_byte[6];
      pkt_prefix_len  <= rx_byte[5:0];
      pkt_prefix      <= '0;
      pkt_data        <= '0;
    end else if (abort) begin
      pkt_prefix <= '0;
      pkt_data   <= '0;
    end else if (shift_prefix) begin
      pkt_prefix <= {pkt_prefix[PW-9:0], rx_byte};
    end else if (shift_data) begin
      pkt_data <= {pkt_data[DW-9:0], rx_byte};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_count <= '0;
      err_pulse  <= 1'b0;
    end else begin
      err_pulse <= drop_byte | abort;
      if (drop_byte && (drop_count != 8'hFF)) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end

  // pkt_valid comes straight from the state flop, so it is registered.
  assign pkt_valid = (state_q == S_HOLD);
  assign dbg_state = state_q;

endmodule
